// File: rtl/best_neighbor_scan.sv
// Walks a neighbour table in memory and reports the lowest-Q neighbour and how many beat my_best.
// Define BETTER_LIST_EN to also write each better neighbour's ID to a list at LIST_BASE.
module best_neighbor_scan #(
    parameter logic [15:0] ADDR_STRIDE   = 16'd2,
    parameter int          MAX_NEIGHBORS = 15,
    parameter logic [15:0] LIST_BASE     = 16'h0400
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] table_base,
    input  logic [15:0] my_best,
    output logic [15:0] mem_address,
    input  logic [15:0] mem_rdata,
    output logic        mem_wr_en,
    output logic [15:0] mem_wdata,
    output logic [15:0] best_value,
    output logic [15:0] best_neighbor_id,
    output logic [15:0] better_count,
    output logic        busy,
    output logic        done
);
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_RD_CNT  = 4'd1;
    localparam logic [3:0] S_CAP_CNT = 4'd2;
    localparam logic [3:0] S_RD_ID   = 4'd3;
    localparam logic [3:0] S_CAP_ID  = 4'd4;
    localparam logic [3:0] S_RD_Q    = 4'd5;
    localparam logic [3:0] S_CAP_Q   = 4'd6;
    localparam logic [3:0] S_FINISH  = 4'd8;
`ifdef BETTER_LIST_EN
    localparam logic [3:0] S_WR_LIST = 4'd7;
`endif
    localparam logic [15:0] MAX_N = 16'(MAX_NEIGHBORS);

    // Word k of the table lives at base + ADDR_STRIDE*k, wrapping in 16 bits.
    function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [15:0] word);
        return base + ADDR_STRIDE * word;
    endfunction

    function automatic logic [15:0] id_word(input logic [15:0] idx);
        return 16'd1 + (idx << 1);
    endfunction

    logic [3:0]  state_q, state_d;
    logic [15:0] base_q, base_d;
    logic [15:0] my_best_q, my_best_d;
    logic [15:0] n_q, n_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] id_tmp_q, id_tmp_d;
    logic [15:0] mem_address_q, mem_address_d;
    logic [15:0] best_value_q, best_value_d;
    logic [15:0] best_id_q, best_id_d;
    logic [15:0] better_count_q, better_count_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] n_clamp;
    logic        advance;
`ifdef BETTER_LIST_EN
    logic        mem_wr_en_q, mem_wr_en_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
`endif

    assign n_clamp = (mem_rdata > MAX_N) ? MAX_N : mem_rdata;

    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        my_best_d      = my_best_q;
        n_d            = n_q;
        idx_d          = idx_q;
        id_tmp_d       = id_tmp_q;
        mem_address_d  = mem_address_q;
        best_value_d   = best_value_q;
        best_id_d      = best_id_q;
        better_count_d = better_count_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        advance        = 1'b0;
`ifdef BETTER_LIST_EN
        mem_wr_en_d    = 1'b0;
        mem_wdata_d    = mem_wdata_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d         = table_base;
                    my_best_d      = my_best;
                    best_value_d   = 16'hFFFF;
                    best_id_d      = 16'hFFFF;
                    better_count_d = 16'd0;
                    idx_d          = 16'd0;
                    busy_d         = 1'b1;
                    mem_address_d  = table_base;
                    state_d        = S_RD_CNT;
                end
            end
            S_RD_CNT: state_d = S_CAP_CNT;
            S_CAP_CNT: begin
                n_d = n_clamp;
                if (n_clamp == 16'd0) begin
                    state_d = S_FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d       = S_RD_ID;
                    mem_address_d = word_addr(base_q, id_word(16'd0));
                end
            end
            S_RD_ID: state_d = S_CAP_ID;
            S_CAP_ID: begin
                id_tmp_d      = mem_rdata;
                state_d       = S_RD_Q;
                mem_address_d = word_addr(base_q, id_word(idx_q) + 16'd1);
            end
            S_RD_Q: state_d = S_CAP_Q;
            S_CAP_Q: begin
                // Strict compare: ties keep the earlier entry and FFFF never displaces the initial FFFF.
                if (mem_rdata < best_value_q) begin
                    best_value_d = mem_rdata;
                    best_id_d    = id_tmp_q;
                end
                idx_d   = idx_q + 16'd1;
                advance = 1'b1;
                if (mem_rdata < my_best_q && better_count_q != 16'hFFFF) begin
                    better_count_d = better_count_q + 16'd1;
`ifdef BETTER_LIST_EN
                    advance       = 1'b0;
                    state_d       = S_WR_LIST;
                    mem_wr_en_d   = 1'b1;
                    mem_wdata_d   = id_tmp_q;
                    mem_address_d = word_addr(LIST_BASE, better_count_q);
`endif
                end
            end
`ifdef BETTER_LIST_EN
            S_WR_LIST: advance = 1'b1;
`endif
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (advance) begin
            if (idx_d < n_q) begin
                state_d       = S_RD_ID;
                mem_address_d = word_addr(base_q, id_word(idx_d));
            end else begin
                state_d = S_FINISH;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            base_q         <= 16'd0;
            my_best_q      <= 16'd0;
            n_q            <= 16'd0;
            idx_q          <= 16'd0;
            id_tmp_q       <= 16'd0;
            mem_address_q  <= 16'd0;
            best_value_q   <= 16'hFFFF;
            best_id_q      <= 16'hFFFF;
            better_count_q <= 16'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            my_best_q      <= my_best_d;
            n_q            <= n_d;
            idx_q          <= idx_d;
            id_tmp_q       <= id_tmp_d;
            mem_address_q  <= mem_address_d;
            best_value_q   <= best_value_d;
            best_id_q      <= best_id_d;
            better_count_q <= better_count_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

`ifdef BETTER_LIST_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_wr_en_q <= 1'b0;
            mem_wdata_q <= 16'd0;
        end else begin
            mem_wr_en_q <= mem_wr_en_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end
    assign mem_wr_en = mem_wr_en_q;
    assign mem_wdata = mem_wdata_q;
`else
    assign mem_wr_en = 1'b0;
    assign mem_wdata = 16'd0;
`endif

    assign mem_address      = mem_address_q;
    assign best_value       = best_value_q;
    assign best_neighbor_id = best_id_q;
    assign better_count     = better_count_q;
    assign busy             = busy_q;
    assign done             = done_q;
endmodule

// File: doc/best_neighbor_scan.md
Name: best_neighbor_scan

Overview:
- Upstream feeder for the winner-policy stage.
- On start, walks the node's neighbour table in shared memory and finds the neighbour with the lowest Q-value (best estimate).
- Counts how many neighbours beat the node's own best estimate.
- Presents best ID, best value and better-count to winnerPolicyV2 (as _bestneighborID/_bestvalue) and rngAddress (as betterNeighborCount), with a one-cycle done pulse.

Parameters:
- ADDR_STRIDE, 2, byte step between consecutive 16-bit words in memory.
- MAX_NEIGHBORS, 15, table length clamp; larger counts read from memory are saturated to this.
- LIST_BASE, 16'h0400, base byte address of the better-neighbour list (used only with BETTER_LIST_EN).

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- table_base  in  16  byte address of table: word0 = count N; entry i: ID at base+ADDR_STRIDE*(1+2i), Q at base+ADDR_STRIDE*(2+2i)
- my_best  in  16  node's own best Q-value, latched at start
- mem_address  out  16  memory address
- mem_rdata  in  16  memory read data, valid one cycle after mem_address
- mem_wr_en  out  1  memory write enable
- mem_wdata  out  16  memory write data
- best_value  out  16  lowest Q-value found (unsigned)
- best_neighbor_id  out  16  ID owning best_value
- better_count  out  16  number of entries with Q < my_best
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse, results valid

Behaviour:
- Reset: synchronously forces all of the following:
  - FSM to IDLE
  - mem_address=0, mem_wr_en=0, mem_wdata=0
  - best_value=16'hFFFF, best_neighbor_id=16'hFFFF, better_count=0
  - busy=0, done=0
- Reset mid-scan aborts immediately: no done pulse, and no write is issued in the reset cycle.
- FSM states: IDLE, RD_CNT, CAP_CNT, RD_ID, CAP_ID, RD_Q, CAP_Q, (WR_LIST), FINISH.
- IDLE:
  - On start=1: latch table_base and my_best; set best_value=FFFF, best_neighbor_id=FFFF, better_count=0, index=0; assert busy; go to RD_CNT.
  - start while busy is ignored.
- RD_CNT: drive mem_address=table_base.
- CAP_CNT:
  - Capture N=min(mem_rdata, MAX_NEIGHBORS).
  - N=0: go to FINISH, outputs stay FFFF/FFFF/0.
  - Otherwise go to RD_ID.
- RD_ID/CAP_ID: address entry ID word; capture the ID into a temp register.
- RD_Q/CAP_Q: address the Q word. In CAP_Q:
  - If Q < best_value (strict, unsigned): update best_value and best_neighbor_id. Ties keep the lower index; Q=FFFF never updates.
  - If Q < my_best: increment better_count, saturating at 16'hFFFF.
  - Increment index; go to RD_ID if index < N, else FINISH.
- Address arithmetic: 16-bit, wraps modulo 2^16 with no error.
- FINISH: done=1 for exactly one cycle, busy=0, return to IDLE.
- Outputs hold their values until the next accepted start.
- Latency, start accepted at cycle 0: done asserts at cycle 3+4N (+1 per better entry with BETTER_LIST_EN); N=0 gives 3.
- start coincident with done: ignored (FSM not yet in IDLE).
- mem_wr_en stays 0 at all times unless BETTER_LIST_EN.

Optional Feature:
- Macro: BETTER_LIST_EN.
- Defined: each entry counted as better is written out, for rngAddress/winnerPolicy random selection.
  - CAP_Q transitions to WR_LIST.
  - WR_LIST drives mem_wr_en=1 for one cycle, mem_address=LIST_BASE+ADDR_STRIDE*(better_count-1) (post-increment count), mem_wdata=entry ID.
  - Then continues to RD_ID or FINISH.
  - If better_count has saturated, no write is issued.
- Undefined: no WR_LIST state; mem_wr_en constant 0, mem_wdata constant 0; latency 3+4N exactly.

Test Plan:
- Reset: assert reset 2 cycles mid-scan (N=4) -> all outputs at reset values next cycle, no done, FSM IDLE; a following start runs a full scan correctly.
- Basic: N=3, (ID,Q)=(4,3),(7,9),(2,1), my_best=5 -> best_neighbor_id=2, best_value=1, better_count=2, done exactly 15 cycles after start (17 with BETTER_LIST_EN, list = [4,2]).
- Empty: N=0 -> done at cycle 3, best_value=FFFF, best_neighbor_id=FFFF, better_count=0, no writes.
- Tie and clamp: N=20, all Q=6, IDs 10..29, my_best=6 -> N clamped to 15, best_neighbor_id=10, best_value=6, better_count=0, done at cycle 63.
- Busy start: pulse start again during scan and on the done cycle -> ignored, single done pulse, results unchanged.
- Wrap: table_base=16'hFFFC, N=1 -> ID fetched from FFFE, Q fetched from 0000, correct result.
